// File: rtl/sram_device_model.sv
// sram_device_model: clocked responder for the board's 16-bit async SRAM.
// Byte-enabled array, fixed-latency read pipe, access counters and flags.
module sram_device_model #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 18,
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic              oor_flag,
  output logic              drive_active
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LAT   = READ_LATENCY;
  localparam int HB    = DATA_W / 2;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_hi;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_out_ub;
  logic                  w_out_lb;

  // Array starts at zero once; reset deliberately leaves it alone.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  logic              r_vld [LAT];
  logic [DATA_W-1:0] r_dat [LAT];
  logic              r_ub  [LAT];
  logic              r_lb  [LAT];

  assign w_wr  = !SRAM_CE_N && !SRAM_WE_N;
  assign w_rd  = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign w_idx = SRAM_ADDR[DEPTH_LOG2-1:0];

  generate
    if (DEPTH_LOG2 < ADDR_W) begin : g_hi
      assign w_hi = |SRAM_ADDR[ADDR_W-1:DEPTH_LOG2];
    end else begin : g_nohi
      assign w_hi = 1'b0;
    end
  endgenerate

  // Byte-masked array write from the DQ bus.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (!SRAM_UB_N) r_mem[w_idx][DATA_W-1:HB] <= SRAM_DQ[DATA_W-1:HB];
      if (!SRAM_LB_N) r_mem[w_idx][HB-1:0]      <= SRAM_DQ[HB-1:0];
    end
  end

  // Read pipe: stage 0 snapshots the word, later stages just shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_dat[i] <= '0;
        r_ub[i]  <= 1'b1;
        r_lb[i]  <= 1'b1;
      end
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) begin
        r_dat[0] <= r_mem[w_idx];
        r_ub[0]  <= SRAM_UB_N;
        r_lb[0]  <= SRAM_LB_N;
      end
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
        r_ub[i]  <= r_ub[i-1];
        r_lb[i]  <= r_lb[i-1];
      end
    end
  end

  // Saturating access counters and sticky out-of-range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
      oor_flag <= 1'b0;
    end else begin
      if (w_wr && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      if (w_rd && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      if ((w_wr || w_rd) && w_hi) oor_flag <= 1'b1;
    end
  end

  // Live read strobes gate the drive so DQ floats the moment they drop.
  assign w_out_ub = r_vld[LAT-1] && w_rd && !r_ub[LAT-1];
  assign w_out_lb = r_vld[LAT-1] && w_rd && !r_lb[LAT-1];

  assign SRAM_DQ[DATA_W-1:HB] =
    w_out_ub ? r_dat[LAT-1][DATA_W-1:HB] : {HB{1'bz}};
  assign SRAM_DQ[HB-1:0] =
    w_out_lb ? r_dat[LAT-1][HB-1:0] : {HB{1'bz}};

  assign drive_active = w_out_ub | w_out_lb;

endmodule

// File: tb/tb_sram_device_model.sv
// tb_sram_device_model: directed bench, latency-1 and latency-3 models
// share stimulus; expected read data flows through a scoreboard queue.
module tb_sram_device_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic        tb_drv;
  logic [15:0] tb_dat;
  wire  [15:0] dq1;
  wire  [15:0] dq3;
  logic [15:0] wc1, rc1, wc3, rc3;
  logic        oor1, oor3, da1, da3;

  int total = 0;
  int bad   = 0;

  logic [15:0] model [4096];
  logic [15:0] exp_q [$];

  assign dq1 = tb_drv ? tb_dat : 16'hzzzz;
  assign dq3 = tb_drv ? tb_dat : 16'hzzzz;

  always #5 clk = ~clk;

  sram_device_model #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wc1), .rd_count(rc1), .oor_flag(oor1),
    .drive_active(da1)
  );

  sram_device_model #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq3), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wc3), .rd_count(rc3), .oor_flag(oor3),
    .drive_active(da3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {16'h0, obs}, {16'h0, e});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    ub_n = 1'b1; lb_n = 1'b1; tb_drv = 1'b0;
    cyc();
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d,
                    input logic ub, input logic lb);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    addr = a; ub_n = ub; lb_n = lb;
    tb_drv = 1'b1; tb_dat = d;
    if (!ub) model[a[11:0]][15:8] = d[15:8];
    if (!lb) model[a[11:0]][7:0]  = d[7:0];
    cyc();
  endtask

  task automatic rd(input logic [17:0] a, input logic ub,
                    input logic lb, input bit push);
    logic [15:0] m;
    logic [7:0]  hi, lo;
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    addr = a; ub_n = ub; lb_n = lb; tb_drv = 1'b0;
    m  = model[a[11:0]];
    hi = ub ? 8'hzz : m[15:8];
    lo = lb ? 8'hzz : m[7:0];
    if (push) exp_q.push_back({hi, lo});
    cyc();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] zz;
    zz = 16'hzzzz;
    for (int i = 0; i < 4096; i++) model[i] = 16'h0;
    rst = 1'b1; addr = '0; tb_dat = '0;
    idle();
    idle();
    chk("rst_wc", {16'h0, wc1}, 32'h0);
    chk("rst_rc", {16'h0, rc1}, 32'h0);
    chk("rst_oor", {31'h0, oor1}, 32'h0);
    chk("rst_da", {31'h0, da1}, 32'h0);
    rst = 1'b0;
    idle();

    wr(18'd5, 16'hBEEF, 1'b0, 1'b0);
    chk("wc_after_wr", {16'h0, wc1}, 32'd1);
    chk("no_drive_on_wr", {31'h0, da1}, 32'h0);
    rd(18'd5, 1'b0, 1'b0, 1'b1);
    sb_chk("rd5", dq1);
    chk("da_rd5", {31'h0, da1}, 32'h1);
    chk("rc_after_rd", {16'h0, rc1}, 32'd1);
    idle();
    chk("da_after_rd", {31'h0, da1}, 32'h0);

    rd(18'd5, 1'b0, 1'b0, 1'b1);
    sb_chk("rd5_again", dq1);
    wr(18'd5, 16'h1111, 1'b0, 1'b0);
    chk("da_rd_then_wr", {31'h0, da1}, 32'h0);
    rd(18'd5, 1'b0, 1'b0, 1'b1);
    sb_chk("rd5_new", dq1);

    wr(18'd7, 16'h1234, 1'b0, 1'b0);
    wr(18'd7, 16'hAB00, 1'b0, 1'b1);
    rd(18'd7, 1'b0, 1'b0, 1'b1);
    sb_chk("rd7_merge", dq1);
    rd(18'd7, 1'b1, 1'b0, 1'b1);
    sb_chk("rd7_lo_only", dq1);
    chk("da_lo_only", {31'h0, da1}, 32'h1);
    rd(18'd7, 1'b1, 1'b1, 1'b0);
    chk("da_no_bytes", {31'h0, da1}, 32'h0);
    idle();

    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) wr(18'(i), 16'(i), 1'b0, 1'b0);
    rd(18'd0, 1'b0, 1'b0, 1'b1);
    chk("l3_da_e0", {31'h0, da3}, 32'h0);
    rd(18'd1, 1'b0, 1'b0, 1'b1);
    chk("l3_da_e1", {31'h0, da3}, 32'h0);
    rd(18'd2, 1'b0, 1'b0, 1'b1);
    sb_chk("l3_w0", dq3);
    rd(18'd3, 1'b0, 1'b0, 1'b1);
    sb_chk("l3_w1", dq3);
    chk("l3_rc", {16'h0, rc3}, 32'd4);
    rd(18'd0, 1'b0, 1'b0, 1'b0);
    sb_chk("l3_w2", dq3);
    rd(18'd0, 1'b0, 1'b0, 1'b0);
    sb_chk("l3_w3", dq3);
    idle();
    chk("l3_da_end", {31'h0, da3}, 32'h0);

    wr(18'd9, 16'hC0DE, 1'b0, 1'b0);
    rd(18'd9, 1'b0, 1'b0, 1'b1);
    sb_chk("rd9", dq1);
    oe_n = 1'b1;
    #1;
    chk("oe_abort_da", {31'h0, da1}, 32'h0);
    chk("oe_abort_dq", {16'h0, dq1}, {16'h0, zz});
    rd(18'd9, 1'b0, 1'b0, 1'b0);
    chk("da_before_rst", {31'h0, da1}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_abort_da", {31'h0, da1}, 32'h0);
    chk("rst_abort_wc", {16'h0, wc1}, 32'h0);
    chk("rst_abort_rc", {16'h0, rc1}, 32'h0);
    cyc();
    rst = 1'b0;
    idle();
    rd(18'd9, 1'b0, 1'b0, 1'b1);
    sb_chk("rd9_kept", dq1);
    idle();

    chk("oor_clear", {31'h0, oor1}, 32'h0);
    wr(18'd4099, 16'h5A5A, 1'b0, 1'b0);
    chk("oor_set", {31'h0, oor1}, 32'h1);
    idle();
    idle();
    chk("oor_sticky", {31'h0, oor1}, 32'h1);
    rd(18'd3, 1'b0, 1'b0, 1'b1);
    sb_chk("rd3_alias", dq1);
    idle();

    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      wr(18'd0, 16'hFFFF, 1'b1, 1'b1);
      if (i == 65533) chk("wc_65534", {16'h0, wc1}, 32'h0000FFFE);
      if (i == 65534) chk("wc_65535", {16'h0, wc1}, 32'h0000FFFF);
    end
    chk("wc_sat", {16'h0, wc1}, 32'h0000FFFF);
    rd(18'd0, 1'b0, 1'b0, 1'b1);
    sb_chk("rd0_unmasked", dq1);
    idle();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
